// File: rtl/aes_bist_pkg.sv
// Shared types and constants for the AES BIST sequencer.
// Pure declarations; no timing or flow control of its own.
package aes_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_RUN,
    ST_COMPARE,
    ST_REPORT
  } bist_state_t;

  localparam int SIG_W  = 8;
  localparam int CYC_W  = 16;
  localparam int DONE_W = 8;

  localparam logic [SIG_W-1:0] AES_BIST_GOLDEN = 8'hC0;

endpackage

// File: rtl/aes_bist_ctrl.sv
// AES BIST sequencer: core reset, LFSR/MISR run, signature compare, pass/fail report.
// done rises RST_CYCLES+RUN_CYCLES+2 edges after start is sampled; held in REPORT until start drops.
module aes_bist_ctrl
  import aes_bist_pkg::*;
#(
  parameter logic [SIG_W-1:0] GOLDEN_SIG = AES_BIST_GOLDEN,
  parameter int               RST_CYCLES = 2,
  parameter int               RUN_CYCLES = 64,
  parameter int               EXP_DONES  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             dut_done,
  input  logic [SIG_W-1:0] sig_in,
  output logic             is_bist,
  output logic             en_lsfr_misr,
  output logic             dut_rst,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] sig_out
);

  localparam logic [CYC_W-1:0] RST_LAST = CYC_W'(RST_CYCLES - 1);
  localparam logic [CYC_W-1:0] RUN_LOAD = CYC_W'(RUN_CYCLES - 1);

  if (RUN_CYCLES < 1 || RUN_CYCLES > 65535) begin : g_bad_run_cycles
    $error("aes_bist_ctrl: RUN_CYCLES must be in 1..65535");
  end
  if (RST_CYCLES < 1 || RST_CYCLES > 15) begin : g_bad_rst_cycles
    $error("aes_bist_ctrl: RST_CYCLES must be in 1..15");
  end

  bist_state_t       state_q, state_d;
  logic [CYC_W-1:0]  cyc_cnt_q, cyc_cnt_d;
  logic [DONE_W-1:0] done_cnt_q, done_cnt_d;
  logic              start_q;
  logic              armed_q, armed_d;
  logic              dut_done_q;
  logic              is_bist_q, is_bist_d;
  logic              en_q, en_d;
  logic              dut_rst_q, dut_rst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [SIG_W-1:0]  sig_q, sig_d;

  always_comb begin
    state_d    = state_q;
    cyc_cnt_d  = cyc_cnt_q;
    done_cnt_d = done_cnt_q;
    armed_d    = armed_q;
    pass_d     = pass_q;
    sig_d      = sig_q;

    case (state_q)
      ST_IDLE: begin
        // A launch needs start to have been seen low first, so a held start never relaunches.
        if (!start) armed_d = 1'b1;
        if (start_q && armed_q) begin
          state_d    = ST_RESET;
          cyc_cnt_d  = '0;
          done_cnt_d = '0;
          armed_d    = 1'b0;
        end
      end
      ST_RESET: begin
        if (cyc_cnt_q == RST_LAST) begin
          state_d   = ST_RUN;
          cyc_cnt_d = RUN_LOAD;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (dut_done && !dut_done_q && (done_cnt_q != {DONE_W{1'b1}})) begin
          done_cnt_d = done_cnt_q + 1'b1;
        end
        if (cyc_cnt_q == '0) state_d = ST_COMPARE;
        else                 cyc_cnt_d = cyc_cnt_q - 1'b1;
      end
      ST_COMPARE: begin
        sig_d   = sig_in;
        pass_d  = (sig_in == GOLDEN_SIG) &&
                  ((EXP_DONES == 0) || (done_cnt_q == DONE_W'(EXP_DONES)));
        state_d = ST_REPORT;
      end
      ST_REPORT: begin
        if (!start) begin
          state_d = ST_IDLE;
          armed_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort discards the run in progress but keeps the last reported result.
    if (abort) begin
      state_d = ST_IDLE;
      armed_d = armed_q;
      pass_d  = pass_q;
      sig_d   = sig_q;
    end

    is_bist_d = (state_d != ST_IDLE);
    en_d      = (state_d == ST_RUN);
    dut_rst_d = (state_d == ST_RESET);
    busy_d    = (state_d == ST_RESET) || (state_d == ST_RUN) || (state_d == ST_COMPARE);
    done_d    = (state_d == ST_REPORT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cyc_cnt_q  <= '0;
      done_cnt_q <= '0;
      start_q    <= 1'b0;
      armed_q    <= 1'b0;
      dut_done_q <= 1'b0;
      is_bist_q  <= 1'b0;
      en_q       <= 1'b0;
      dut_rst_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      sig_q      <= '0;
    end else begin
      state_q    <= state_d;
      cyc_cnt_q  <= cyc_cnt_d;
      done_cnt_q <= done_cnt_d;
      start_q    <= start;
      armed_q    <= armed_d;
      dut_done_q <= dut_done;
      is_bist_q  <= is_bist_d;
      en_q       <= en_d;
      dut_rst_q  <= dut_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      sig_q      <= sig_d;
    end
  end

  assign is_bist      = is_bist_q;
  assign en_lsfr_misr = en_q;
  assign dut_rst      = dut_rst_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign sig_out      = sig_q;

endmodule

// File: doc/aes_bist_ctrl.md
# aes_bist_ctrl

Self-test sequencer for the 8-bit AES BIST wrapper. On a start request it resets the AES core and puts the wrapper in BIST mode. It then runs the LFSR/MISR pair for a fixed number of cycles, freezes the MISR, and compares the signature against a golden value. It reports pass/fail over a level start/done handshake and sits between the test-access/host logic and the wrapper's `is_bist`, `en_lsfr_misr` and core-reset inputs.

## Interface
- `GOLDEN_SIG`, 8'hC0, expected MISR signature after a full run
- `RST_CYCLES`, 2, cycles `dut_rst` is held high before the run (1..15)
- `RUN_CYCLES`, 64, cycles `en_lsfr_misr` is held high (1..65535)
- `EXP_DONES`, 0, required count of `dut_done` rising edges during the run; 0 disables the check
- `clk`  in  1  clock; all logic on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  level request; rising level in IDLE launches a test
- `abort`  in  1  synchronous abort; returns to IDLE from any state
- `dut_done`  in  1  wrapper `DONE`
- `sig_in`  in  8  wrapper `d_out`, which is the MISR signature while `is_bist`=1
- `is_bist`  out  1  wrapper mode select
- `en_lsfr_misr`  out  1  LFSR/MISR enable
- `dut_rst`  out  1  active-high reset to the wrapper/core
- `busy`  out  1  high in RESET, RUN, COMPARE
- `done`  out  1  result valid, high in REPORT
- `pass`  out  1  result; valid while `done`=1
- `sig_out`  out  8  captured signature; held until the next COMPARE

## Operation
- States: IDLE, RESET, RUN, COMPARE, REPORT. The state type is an enum.
- IDLE: all control outputs are 0. `start`=1 moves to RESET and clears the cycle counter and done counter.
- RESET: `dut_rst`=1 and `is_bist`=1 for exactly RST_CYCLES cycles, then RUN.
- RUN: `is_bist`=1 and `en_lsfr_misr`=1 for exactly RUN_CYCLES cycles.
  - A 16-bit down-counter loads RUN_CYCLES-1 on entry.
  - The state leaves to COMPARE in the cycle after the counter reads 0.
  - The `dut_done` rising-edge counter is 8 bits and saturates at 255.
- COMPARE: one cycle, `en_lsfr_misr`=0, `is_bist`=1.
  - Registers `sig_out`<=`sig_in`.
  - `pass`<= (`sig_in`==GOLDEN_SIG) && (EXP_DONES==0 || done_cnt==EXP_DONES).
- REPORT: `done`=1, `is_bist`=1 (the signature stays visible). Remains in REPORT while `start`=1; `start`=0 moves to IDLE.
- `abort`=1 in any state: next state IDLE, all control outputs drop next cycle, `pass` and `sig_out` are unchanged. `abort` has priority over `start`.
- `start` held high across REPORT→IDLE does not relaunch; a new launch requires `start` to be seen low in IDLE or REPORT first.
- `dut_done` rising edges outside RUN are ignored.
- Elaboration assertions: RUN_CYCLES≥1 and 1≤RST_CYCLES≤15.

## Timing
- Async reset (`rst`=0): state IDLE; `is_bist`, `en_lsfr_misr`, `dut_rst`, `busy`, `done`, `pass`=0; `sig_out`=8'h00. All counters are 0.
- Reset asserted mid-test aborts immediately with no result. After release the block waits in IDLE for a fresh `start` edge.
- Start at edge N, with `start` registered in IDLE:
  - RESET occupies edges N+1 .. N+RST_CYCLES.
  - RUN occupies the next RUN_CYCLES cycles.
  - COMPARE is 1 cycle.
  - `done` rises at edge N+RST_CYCLES+RUN_CYCLES+2.
- `en_lsfr_misr` high count per test is exactly RUN_CYCLES; there are no glitch cycles at state boundaries.
- `done` falls one cycle after `start` is sampled low.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Package `aes_bist_pkg`: state enum `bist_state_t`, the `AES_BIST_GOLDEN` constant (8'hC0), and counter width localparams.
- The controller is a single module. Counters and the rising-edge detector are inline; no sub-module is warranted.
- The bench instantiates the controller together with `aes_top_bist`, connected one-to-one on the BIST pins.

## Test plan
- Defaults, connected to the real wrapper, `start` pulsed high and held: `dut_rst` is high 2 cycles; `en_lsfr_misr` is high exactly 64 cycles; `done` rises at edge start+68; `sig_out`=8'hC0; `pass`=1.
- Stub `sig_in` forced to 8'hC1: `done`=1, `pass`=0, `sig_out`=8'hC1.
- EXP_DONES=3 with the stub toggling `dut_done` twice during RUN: `pass`=0 even though `sig_in`=8'hC0. With three toggles, `pass`=1.
- `abort` asserted at the 10th RUN cycle: the next cycle is IDLE, with `en_lsfr_misr`, `is_bist` and `busy` at 0. `done` never rises, and the previous `pass`/`sig_out` are kept.
- `rst` driven low mid-RUN for 1 cycle: all outputs are 0 asynchronously. With `start` held high the block stays in IDLE. After `start` is low then high again, a full 68-cycle run completes.
- RUN_CYCLES=1, RST_CYCLES=1: `en_lsfr_misr` is high exactly 1 cycle and `done` rises at start+4. Releasing `start` drops `done` next cycle, and a back-to-back restart works.
